pc_fetch_align: RTL and testbench
=================================

// Module: pc_fetch_align
// PURPOSE
//  Parametrised program-counter and fetch-alignment unit for the RV32IC core (IF stage).
//  Holds the PC and selects the next PC from: trap vector, mret (mepc), branch/jump target, or sequential step.
//  Sequential step is +2 (compressed) or +4.
//  Reads word-aligned imem, assembles 16/32-bit instructions incl. 32-bit instructions straddling a word boundary (2-cycle SPLIT).
// PARAMETERS
//  XLEN       32  PC / address width
//  RESET_VEC  0   PC value loaded on reset
//  C_EXT      1   1: compressed support (+2 step, halfword PCs); 0: +4 only, PC[1] forced 0
//  CAUSE_W    5   width of cause_i
// PORTS
//  clk            in   1         clock, rising edge
//  reset          in   1         asynchronous, active-low reset
//  stall_i        in   1         hold PC (sequential/branch update suppressed)
//  br_taken_i     in   1         branch/jump taken
//  br_target_i    in   XLEN      branch/jump target (ALU result)
//  trap_i         in   1         take trap/interrupt this cycle
//  irq_i          in   1         trap is an interrupt (enables vectoring)
//  cause_i        in   CAUSE_W   trap cause code
//  mtvec_i        in   XLEN      CSR mtvec; [1:0]=mode
//  mret_i         in   1         return from trap
//  mepc_i         in   XLEN      CSR mepc
//  imem_rdata_i   in   32        imem word at fetch_addr_o, same cycle (combinational read)
//  pc_o           out  XLEN      address of instruction in instr_o
//  pc_plus_o      out  XLEN      pc_o+2 if compressed_o else pc_o+4 (link value)
//  fetch_addr_o   out  XLEN      word-aligned imem address, [1:0]=0
//  instr_o        out  32        assembled instruction; compressed: {16'b0,hw}
//  instr_valid_o  out  1         instr_o complete, decode may consume
//  compressed_o   out  1         instr_o is 16-bit (hw[1:0]!=2'b11)
//  split_o        out  1         FSM in SPLIT
//  misalign_o     out  1         registered 1-cycle pulse: a redirect target was masked
// BEHAVIOUR
//  Reset (reset=0, async): pc_o=RESET_VEC, state=RUN, hw_buf=0, misalign_o=0.
//  Comb. outputs then follow from pc_o.
//  RUN, pc_o[1]=0: fetch_addr=pc_o; instr=rdata (or {16'b0,rdata[15:0]} if compressed); valid=1.
//  RUN, pc_o[1]=1: fetch_addr={pc_o[XLEN-1:2],2'b00}; hw=rdata[31:16].
//    - hw compressed: instr={16'b0,hw}, valid=1.
//    - else: valid=0, hw_buf<=hw, next state SPLIT, pc held; this happens even if stall_i=1.
//  SPLIT: fetch_addr={pc_o[XLEN-1:2],2'b00}+4; instr={rdata[15:0],hw_buf}; valid=1; compressed=0.
//    Leaves to RUN when PC updates (no stall). Under stall: stays in SPLIT, hw_buf held.
//  Next-PC priority, evaluated at each rising edge:
//    1. trap_i   : PC <= trap target (overrides stall and SPLIT)
//    2. mret_i   : PC <= mepc_i (overrides stall and SPLIT)
//    3. stall_i  : PC held
//    4. br_taken_i: PC <= br_target_i
//    5. valid=1  : PC <= pc_plus_o
//    6. valid=0  : PC held (RUN->SPLIT transition)
//  Any redirect (1, 2, 4) forces state=RUN; in SPLIT, hw_buf is discarded.
//  Trap target: base={mtvec_i[XLEN-1:2],2'b00}.
//    - mode=1 and irq_i=1: base + (cause_i<<2).
//    - otherwise: base (modes 2/3 treated as direct).
//  Arithmetic: all sums are modulo 2^XLEN; wrap-around is silent (0xFFFF_FFFC+4=0).
//  Target masking: bit0 always cleared; with C_EXT=0, bit1 also cleared.
//    misalign_o=1 in the next cycle iff a masked bit was 1; no other effect.
//  C_EXT=0: step always +4; compressed_o=0; SPLIT unreachable.
//  Simultaneous trap_i and mret_i: trap wins. Simultaneous br_taken_i and stall_i: stall wins (branch lost).
// TESTING
//  1. Reset low mid-SPLIT -> same cycle pc_o=RESET_VEC, split_o=0; after release, fetch from 0x0.
//  2. Stream at 0x100: 32b, 16b, 32b -> pc_o 0x100, 0x104, 0x106.
//     At 0x106: split_o=1 for one cycle; instr_o={word@0x108[15:0], word@0x104[31:16]}; next pc_o=0x10A.
//  3. Vectored trap: mtvec=0x8000_0001, irq_i=1, cause=7 -> pc_o=0x8000_001C.
//     Same with irq_i=0 -> 0x8000_0000.
//  4. stall_i=1 with br_taken_i=1 for 3 cycles -> pc_o constant.
//     stall_i=1 with trap_i=1 -> redirect taken next edge.
//  5. br_target=0x203 with C_EXT=1 -> pc_o=0x202, misalign_o pulses 1 cycle.
//     With C_EXT=0 -> pc_o=0x200.
//  6. pc_o=0xFFFF_FFFC, 32-bit instr, no stall -> pc_o=0x0000_0000 (wrap).
//     mret_i with trap_i -> trap target wins.

Source files
------------

// File: rtl/pc_fetch_align.sv
// Program counter and fetch-alignment unit for the RV32IC IF stage.
// Selects the next PC and assembles 16/32-bit instructions from word-aligned imem, including boundary-straddling ones.
module pc_fetch_align #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int unsigned     C_EXT     = 1,
    parameter int unsigned     CAUSE_W   = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_i,
    input  logic               br_taken_i,
    input  logic [XLEN-1:0]    br_target_i,
    input  logic               trap_i,
    input  logic               irq_i,
    input  logic [CAUSE_W-1:0] cause_i,
    input  logic [XLEN-1:0]    mtvec_i,
    input  logic               mret_i,
    input  logic [XLEN-1:0]    mepc_i,
    input  logic [31:0]        imem_rdata_i,
    output logic [XLEN-1:0]    pc_o,
    output logic [XLEN-1:0]    pc_plus_o,
    output logic [XLEN-1:0]    fetch_addr_o,
    output logic [31:0]        instr_o,
    output logic               instr_valid_o,
    output logic               compressed_o,
    output logic               split_o,
    output logic               misalign_o
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_SPLIT = 1'b1
    } state_e;

    // Bits a redirect target may not carry: bit0 always, bit1 too without compressed support
    localparam logic [XLEN-1:0] ALIGN_MASK = (C_EXT != 0) ? ~XLEN'(1) : ~XLEN'(3);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [15:0]     hw_buf_q, hw_buf_d;
    logic            misalign_q, misalign_d;

    logic [XLEN-1:0] word_addr;
    logic [XLEN-1:0] fetch_addr_c;
    logic [XLEN-1:0] pc_plus_c;
    logic [XLEN-1:0] trap_tgt_c;
    logic [XLEN-1:0] target_c;
    logic [31:0]     instr_c;
    logic [15:0]     hw_c;
    logic            valid_c;
    logic            comp_c;
    logic            redirect_c;

    assign word_addr = {pc_q[XLEN-1:2], 2'b00};

    // Instruction assembly from the current fetch word
    always_comb begin
        fetch_addr_c = word_addr;
        instr_c      = imem_rdata_i;
        hw_c         = imem_rdata_i[31:16];
        valid_c      = 1'b1;
        comp_c       = 1'b0;
        case (state_q)
            ST_RUN: begin
                if ((C_EXT != 0) && pc_q[1]) begin
                    if (hw_c[1:0] != 2'b11) begin
                        comp_c  = 1'b1;
                        instr_c = {16'b0, hw_c};
                    end else begin
                        valid_c = 1'b0;
                    end
                end else if ((C_EXT != 0) && (imem_rdata_i[1:0] != 2'b11)) begin
                    comp_c  = 1'b1;
                    instr_c = {16'b0, imem_rdata_i[15:0]};
                end
            end
            ST_SPLIT: begin
                fetch_addr_c = word_addr + XLEN'(4);
                instr_c      = {imem_rdata_i[15:0], hw_buf_q};
            end
            default: begin
                valid_c = 1'b1;
            end
        endcase
    end

    assign pc_plus_c  = pc_q + (comp_c ? XLEN'(2) : XLEN'(4));
    assign trap_tgt_c = {mtvec_i[XLEN-1:2], 2'b00}
                      + (((mtvec_i[1:0] == 2'b01) && irq_i) ? (XLEN'(cause_i) << 2) : '0);

    // Next-PC selection: trap > mret > stall > branch > sequential
    always_comb begin
        pc_d       = pc_q;
        state_d    = state_q;
        hw_buf_d   = hw_buf_q;
        misalign_d = 1'b0;
        redirect_c = 1'b0;
        target_c   = '0;
        if (trap_i) begin
            redirect_c = 1'b1;
            target_c   = trap_tgt_c;
        end else if (mret_i) begin
            redirect_c = 1'b1;
            target_c   = mepc_i;
        end else if (stall_i) begin
            // The upper half-word is still captured so the split resumes after the stall
            if ((state_q == ST_RUN) && !valid_c) begin
                state_d  = ST_SPLIT;
                hw_buf_d = hw_c;
            end
        end else if (br_taken_i) begin
            redirect_c = 1'b1;
            target_c   = br_target_i;
        end else if (valid_c) begin
            pc_d    = pc_plus_c;
            state_d = ST_RUN;
        end else begin
            state_d  = ST_SPLIT;
            hw_buf_d = hw_c;
        end
        if (redirect_c) begin
            pc_d       = target_c & ALIGN_MASK;
            misalign_d = |(target_c & ~ALIGN_MASK);
            state_d    = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_VEC;
            hw_buf_q   <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            hw_buf_q   <= hw_buf_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc_o          = pc_q;
    assign pc_plus_o     = pc_plus_c;
    assign fetch_addr_o  = fetch_addr_c;
    assign instr_o       = instr_c;
    assign instr_valid_o = valid_c;
    assign compressed_o  = comp_c;
    assign split_o       = (state_q == ST_SPLIT);
    assign misalign_o    = misalign_q;

endmodule

// File: tb/tb_pc_fetch_align.sv
// Directed bench for pc_fetch_align: one compressed-capable and one 32-bit-only instance share stimulus.
module tb_pc_fetch_align;

    logic        clk;
    logic        reset;
    logic        stall_i, br_taken_i, trap_i, irq_i, mret_i;
    logic [31:0] br_target_i, mtvec_i, mepc_i;
    logic [4:0]  cause_i;
    logic [31:0] mem [256];

    logic [31:0] c_rdata, c_pc, c_pc_plus, c_fetch, c_instr;
    logic        c_valid, c_comp, c_split, c_mis;
    logic [31:0] n_rdata, n_pc, n_pc_plus, n_fetch, n_instr;
    logic        n_valid, n_comp, n_split, n_mis;

    int total = 0;
    int bad   = 0;

    assign c_rdata = mem[c_fetch[9:2]];
    assign n_rdata = mem[n_fetch[9:2]];

    pc_fetch_align #(.XLEN(32), .RESET_VEC(32'h0), .C_EXT(1), .CAUSE_W(5)) u_c (
        .clk(clk), .reset(reset), .stall_i(stall_i), .br_taken_i(br_taken_i),
        .br_target_i(br_target_i), .trap_i(trap_i), .irq_i(irq_i), .cause_i(cause_i),
        .mtvec_i(mtvec_i), .mret_i(mret_i), .mepc_i(mepc_i), .imem_rdata_i(c_rdata),
        .pc_o(c_pc), .pc_plus_o(c_pc_plus), .fetch_addr_o(c_fetch), .instr_o(c_instr),
        .instr_valid_o(c_valid), .compressed_o(c_comp), .split_o(c_split), .misalign_o(c_mis)
    );

    pc_fetch_align #(.XLEN(32), .RESET_VEC(32'h0), .C_EXT(0), .CAUSE_W(5)) u_n (
        .clk(clk), .reset(reset), .stall_i(stall_i), .br_taken_i(br_taken_i),
        .br_target_i(br_target_i), .trap_i(trap_i), .irq_i(irq_i), .cause_i(cause_i),
        .mtvec_i(mtvec_i), .mret_i(mret_i), .mepc_i(mepc_i), .imem_rdata_i(n_rdata),
        .pc_o(n_pc), .pc_plus_o(n_pc_plus), .fetch_addr_o(n_fetch), .instr_o(n_instr),
        .instr_valid_o(n_valid), .compressed_o(n_comp), .split_o(n_split), .misalign_o(n_mis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall_i = 0; br_taken_i = 0; trap_i = 0; irq_i = 0; mret_i = 0;
        br_target_i = 0; mtvec_i = 0; mepc_i = 0; cause_i = 0;
    endtask

    task automatic branch_to(input logic [31:0] t);
        br_taken_i = 1; br_target_i = t;
        tick();
        br_taken_i = 0;
    endtask

    task automatic test_reset();
        reset = 0;
        idle_inputs();
        tick(); tick();
        total++; if (c_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", c_pc, 32'h0); end
        total++; if (c_split !== 1'b0) begin bad++; $display("FAIL reset_split got=%b exp=0", c_split); end
        total++; if (c_mis !== 1'b0) begin bad++; $display("FAIL reset_misalign got=%b exp=0", c_mis); end
        total++; if (c_instr !== 32'h0000_0013) begin bad++; $display("FAIL reset_instr got=%h exp=%h", c_instr, 32'h13); end
        reset = 1;
        tick();
        total++; if (c_pc !== 32'h4) begin bad++; $display("FAIL reset_first_step got=%h exp=%h", c_pc, 32'h4); end
    endtask

    task automatic test_stream();
        branch_to(32'h100);
        total++; if (c_pc !== 32'h100) begin bad++; $display("FAIL stream_pc0 got=%h exp=%h", c_pc, 32'h100); end
        total++; if (c_instr !== 32'h1234_5677) begin bad++; $display("FAIL stream_instr0 got=%h exp=%h", c_instr, 32'h12345677); end
        total++; if (c_pc_plus !== 32'h104) begin bad++; $display("FAIL stream_plus0 got=%h exp=%h", c_pc_plus, 32'h104); end
        tick();
        total++; if (c_pc !== 32'h104) begin bad++; $display("FAIL stream_pc1 got=%h exp=%h", c_pc, 32'h104); end
        total++; if (c_comp !== 1'b1 || c_instr !== 32'h0000_4501) begin bad++; $display("FAIL stream_c16 got=%b/%h exp=1/%h", c_comp, c_instr, 32'h4501); end
        total++; if (c_pc_plus !== 32'h106) begin bad++; $display("FAIL stream_plus1 got=%h exp=%h", c_pc_plus, 32'h106); end
        total++; if (n_comp !== 1'b0 || n_instr !== 32'hABC3_4501 || n_pc_plus !== 32'h108) begin
            bad++; $display("FAIL noc_step got=%b/%h/%h exp=0/%h/%h", n_comp, n_instr, n_pc_plus, 32'hABC34501, 32'h108); end
        tick();
        total++; if (c_pc !== 32'h106 || c_valid !== 1'b0 || c_split !== 1'b0) begin
            bad++; $display("FAIL stream_pc2 got=%h/v%b/s%b exp=106/v0/s0", c_pc, c_valid, c_split); end
        tick();
        total++; if (c_split !== 1'b1 || c_fetch !== 32'h108) begin bad++; $display("FAIL split_state got=s%b/%h exp=s1/%h", c_split, c_fetch, 32'h108); end
        total++; if (c_instr !== 32'hDEF7_ABC3 || c_valid !== 1'b1 || c_comp !== 1'b0) begin
            bad++; $display("FAIL split_instr got=%h/v%b/c%b exp=%h/v1/c0", c_instr, c_valid, c_comp, 32'hDEF7ABC3); end
        tick();
        total++; if (c_pc !== 32'h10A || c_split !== 1'b0) begin bad++; $display("FAIL split_exit got=%h/s%b exp=%h/s0", c_pc, c_split, 32'h10A); end
    endtask

    task automatic test_reset_mid_split();
        branch_to(32'h106);
        tick();
        total++; if (c_split !== 1'b1) begin bad++; $display("FAIL mid_split_enter got=%b exp=1", c_split); end
        reset = 0;
        #1;
        total++; if (c_pc !== 32'h0 || c_split !== 1'b0) begin bad++; $display("FAIL mid_split_reset got=%h/s%b exp=0/s0", c_pc, c_split); end
        reset = 1;
        #1;
        total++; if (c_fetch !== 32'h0) begin bad++; $display("FAIL mid_split_fetch got=%h exp=0", c_fetch); end
    endtask

    task automatic test_trap();
        mtvec_i = 32'h8000_0001; irq_i = 1; cause_i = 5'd7; trap_i = 1;
        tick();
        total++; if (c_pc !== 32'h8000_001C) begin bad++; $display("FAIL trap_vectored got=%h exp=%h", c_pc, 32'h8000001C); end
        irq_i = 0;
        tick();
        total++; if (c_pc !== 32'h8000_0000) begin bad++; $display("FAIL trap_direct got=%h exp=%h", c_pc, 32'h80000000); end
        total++; if (c_mis !== 1'b0) begin bad++; $display("FAIL trap_misalign got=%b exp=0", c_mis); end
        idle_inputs();
    endtask

    task automatic test_stall();
        branch_to(32'h40);
        stall_i = 1; br_taken_i = 1; br_target_i = 32'h300;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (c_pc !== 32'h40) begin bad++; $display("FAIL stall_hold%0d got=%h exp=%h", i, c_pc, 32'h40); end
        end
        br_taken_i = 0; trap_i = 1; mtvec_i = 32'h200;
        tick();
        total++; if (c_pc !== 32'h200) begin bad++; $display("FAIL stall_trap got=%h exp=%h", c_pc, 32'h200); end
        idle_inputs();
    endtask

    task automatic test_misalign();
        branch_to(32'h203);
        total++; if (c_pc !== 32'h202 || c_mis !== 1'b1) begin bad++; $display("FAIL mis_c got=%h/m%b exp=%h/m1", c_pc, c_mis, 32'h202); end
        total++; if (n_pc !== 32'h200 || n_mis !== 1'b1) begin bad++; $display("FAIL mis_noc got=%h/m%b exp=%h/m1", n_pc, n_mis, 32'h200); end
        tick();
        total++; if (c_mis !== 1'b0) begin bad++; $display("FAIL mis_pulse got=%b exp=0", c_mis); end
        branch_to(32'h202);
        total++; if (c_mis !== 1'b0 || n_mis !== 1'b1 || n_pc !== 32'h200) begin
            bad++; $display("FAIL mis_bit1 got=c%b/n%b/%h exp=c0/n1/%h", c_mis, n_mis, n_pc, 32'h200); end
    endtask

    task automatic test_wrap_and_priority();
        branch_to(32'hFFFF_FFFC);
        total++; if (c_pc_plus !== 32'h0) begin bad++; $display("FAIL wrap_plus got=%h exp=0", c_pc_plus); end
        tick();
        total++; if (c_pc !== 32'h0) begin bad++; $display("FAIL wrap_pc got=%h exp=0", c_pc); end
        trap_i = 1; mret_i = 1; mtvec_i = 32'h300; mepc_i = 32'h500;
        tick();
        total++; if (c_pc !== 32'h300) begin bad++; $display("FAIL trap_over_mret got=%h exp=%h", c_pc, 32'h300); end
        trap_i = 0; stall_i = 1;
        tick();
        total++; if (c_pc !== 32'h500) begin bad++; $display("FAIL mret got=%h exp=%h", c_pc, 32'h500); end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
        mem[8'h40] = 32'h1234_5677;
        mem[8'h41] = 32'hABC3_4501;
        mem[8'h42] = 32'h1111_DEF7;
        mem[8'h80] = 32'h0000_0013;
        test_reset();
        test_stream();
        test_reset_mid_split();
        test_trap();
        test_stall();
        test_misalign();
        test_wrap_and_priority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
